// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: assembles WIDTH framed serial bits into a word
// and offers it on a valid/ready port. Flags dropped words (sticky overrun) and
// mid-word frame starts (one-cycle frame_err).
module serial_to_parallel_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic [WIDTH-1:0]  sr_shift;   // shift register with ser_in appended
  logic [WIDTH-1:0]  sr_first;   // fresh word holding only ser_in as its first bit
  logic              in_shift;
  logic              start;      // frame_start bit, from either state
  logic              resync;     // frame_start arriving mid-word
  logic              advance;    // ordinary data bit inside a word
  logic              last_bit;
  logic              complete;
  logic              load;       // completed word may enter the holding register
  logic              drop;       // completed word lost because the holder is full

  // Bit ordering is a static choice; only one shift direction is built.
  if (MSB_FIRST) begin : g_msb_first
    assign sr_shift = {sr_q[WIDTH-2:0], ser_in};
    assign sr_first = {{(WIDTH-1){1'b0}}, ser_in};
  end else begin : g_lsb_first
    assign sr_shift = {ser_in, sr_q[WIDTH-1:1]};
    assign sr_first = {ser_in, {(WIDTH-1){1'b0}}};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a frame start always lands in SHIFT, the last bit returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ser_valid && frame_start) state_d = StShift;
      end
      StShift: begin
        if (ser_valid && !frame_start && last_bit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and event decode.
  always_comb begin
    in_shift = (state_q == StShift);
    busy     = in_shift;
    start    = ser_valid && frame_start;
    resync   = in_shift && start;
    advance  = in_shift && ser_valid && !frame_start;
    last_bit = (bit_cnt_q == CntW'(WIDTH - 1));
    complete = advance && last_bit;
    load     = complete && (!valid_q || out_ready);
    drop     = complete && valid_q && !out_ready;
  end

  // Datapath next state: bit counter, shift register, holding register and flags.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = resync;

    if (start) begin
      bit_cnt_d = CntW'(1);
      sr_d      = sr_first;
    end else if (complete) begin
      bit_cnt_d = '0;
      sr_d      = sr_shift;
    end else if (advance) begin
      bit_cnt_d = bit_cnt_q + CntW'(1);
      sr_d      = sr_shift;
    end

    // A full holder being drained this cycle can take the new word with no bubble.
    if (load) begin
      data_d  = sr_shift;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // Setting wins over a simultaneous clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: an MSB-first and an LSB-first instance share
// the same stimulus and are checked every cycle against a bit-list reference model.
module tb_serial_to_parallel_rx;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset, ser_in, ser_valid, frame_start, out_ready, clr_overrun;

  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, ovr_m, ovr_l, fe_m, fe_l, busy_m, busy_l;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  serial_to_parallel_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clr_overrun(clr_overrun),
    .data_out(data_m), .out_valid(valid_m), .overrun(ovr_m), .frame_err(fe_m),
    .busy(busy_m)
  );

  serial_to_parallel_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clr_overrun(clr_overrun),
    .data_out(data_l), .out_valid(valid_l), .overrun(ovr_l), .frame_err(fe_l),
    .busy(busy_l)
  );

  // Reference model: the current frame is simply the list of bits received so far.
  logic         mq[$];
  logic [W-1:0] m_dm, m_dl;
  logic         m_valid, m_ovr, m_fe, m_busy;

  wire [W+3:0] obs_m = {data_m, valid_m, ovr_m, fe_m, busy_m};
  wire [W+3:0] obs_l = {data_l, valid_l, ovr_l, fe_l, busy_l};
  wire [W+3:0] exp_m = {m_dm, m_valid, m_ovr, m_fe, m_busy};
  wire [W+3:0] exp_l = {m_dl, m_valid, m_ovr, m_fe, m_busy};

  task automatic model_reset();
    mq.delete();
    m_dm = '0; m_dl = '0; m_valid = 0; m_ovr = 0; m_fe = 0; m_busy = 0;
  endtask

  // Advance one clock, apply the sampled inputs to the model, settle 1 time unit.
  task automatic cycle();
    logic         done, fe_n, set_ovr;
    logic [W-1:0] wm, wl;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      done = 0; fe_n = 0; wm = '0; wl = '0;
      if (ser_valid) begin
        if (frame_start) begin
          fe_n = (mq.size() != 0);
          mq.delete();
          mq.push_back(ser_in);
        end else if (mq.size() != 0) begin
          mq.push_back(ser_in);
          if (mq.size() == W) begin
            done = 1;
            for (int i = 0; i < W; i++) begin
              wm[W-1-i] = mq[i];
              wl[i]     = mq[i];
            end
            mq.delete();
          end
        end
      end
      set_ovr = done && m_valid && !out_ready;
      if (done && !set_ovr) begin
        m_dm = wm; m_dl = wl; m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (set_ovr) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      m_fe   = fe_n;
      m_busy = (mq.size() != 0);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic fs);
    ser_valid   = v;
    frame_start = fs;
    ser_in      = v ? b : 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    reset = 1; ser_valid = 0; frame_start = 0; out_ready = 0; clr_overrun = 0; ser_in = 0;
    model_reset();
    @(posedge clk); #1;
    tests++;
    if (obs_m !== '0 || obs_l !== '0) begin
      fails++;
      $display("FAIL reset_state: got msb=%b lsb=%b want all zero", obs_m, obs_l);
    end
    reset = 0;
    drive(1, 1, 0);
    cycle();
    tests++;
    if (obs_m !== exp_m || obs_l !== exp_l || busy_m !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_frame: got msb=%b lsb=%b want msb=%b lsb=%b",
               obs_m, obs_l, exp_m, exp_l);
    end
  endtask

  task automatic test_single();
    logic [3:0] w = 4'b1011;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, w[3-i], i == 0);
      cycle();
      tests++;
      if (obs_m !== exp_m || obs_l !== exp_l || valid_m !== (i == 3)) begin
        fails++;
        $display("FAIL single_bit%0d: got msb=%b lsb=%b want msb=%b lsb=%b",
                 i, obs_m, obs_l, exp_m, exp_l);
      end
    end
    tests++;
    if (data_m !== 4'b1011 || data_l !== 4'b1101 || valid_m !== 1'b1) begin
      fails++;
      $display("FAIL single_word: got msb=%b lsb=%b v=%b want 1011 1101 1", data_m, data_l,
               valid_m);
    end
    drive(0, 0, 0);
    cycle();
    tests++;
    if (valid_m !== 1'b0 || valid_l !== 1'b0 || obs_m !== exp_m) begin
      fails++;
      $display("FAIL single_one_cycle: got valid=%b/%b want 0", valid_m, valid_l);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] w = 4'b1011;
    int gap;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      gap = (i == 0) ? 0 : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        drive(0, 0, 0);
        cycle();
        tests++;
        if (obs_m !== exp_m || obs_l !== exp_l || busy_m !== 1'b1) begin
          fails++;
          $display("FAIL gaps_idle: got msb=%b lsb=%b want msb=%b lsb=%b busy=1",
                   obs_m, obs_l, exp_m, exp_l);
        end
      end
      drive(1, w[3-i], i == 0);
      cycle();
      tests++;
      if (obs_m !== exp_m || obs_l !== exp_l) begin
        fails++;
        $display("FAIL gaps_bit%0d: got msb=%b lsb=%b want msb=%b lsb=%b",
                 i, obs_m, obs_l, exp_m, exp_l);
      end
    end
    tests++;
    if (data_m !== 4'b1011 || valid_m !== 1'b1) begin
      fails++;
      $display("FAIL gaps_word: got %b v=%b want 1011 v=1", data_m, valid_m);
    end
    drive(0, 0, 0);
    cycle();
  endtask

  task automatic test_overrun();
    logic [7:0] bits = 8'b1100_0011;
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, bits[7-i], (i % 4) == 0);
      cycle();
      tests++;
      if (obs_m !== exp_m || obs_l !== exp_l) begin
        fails++;
        $display("FAIL overrun_bit%0d: got msb=%b lsb=%b want msb=%b lsb=%b",
                 i, obs_m, obs_l, exp_m, exp_l);
      end
    end
    tests++;
    if (data_m !== 4'b1100 || ovr_m !== 1'b1 || ovr_l !== 1'b1 || valid_m !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got data=%b ovr=%b v=%b want 1100 1 1", data_m, ovr_m, valid_m);
    end
    clr_overrun = 1;
    drive(0, 0, 0);
    cycle();
    clr_overrun = 0;
    tests++;
    if (ovr_m !== 1'b0 || data_m !== 4'b1100 || valid_m !== 1'b1 || obs_m !== exp_m) begin
      fails++;
      $display("FAIL overrun_clear: got ovr=%b data=%b v=%b want 0 1100 1", ovr_m, data_m,
               valid_m);
    end
    out_ready = 1;
    cycle();
    tests++;
    if (valid_m !== 1'b0 || obs_m !== exp_m || obs_l !== exp_l) begin
      fails++;
      $display("FAIL overrun_drain: got valid=%b want 0", valid_m);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits = 12'hA5F;
    logic [3:0]  words[3] = '{4'hA, 4'h5, 4'hF};
    int ntx = 0;
    out_ready = 1;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) drive(1, bits[11-i], (i % 4) == 0);
      else drive(0, 0, 0);
      cycle();
      tests++;
      if (obs_m !== exp_m || obs_l !== exp_l) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got msb=%b lsb=%b want msb=%b lsb=%b",
                 i, obs_m, obs_l, exp_m, exp_l);
      end
      if (valid_m === 1'b1) begin
        tests++;
        if (ntx > 2 || data_m !== words[ntx % 3]) begin
          fails++;
          $display("FAIL b2b_order: transfer %0d got %h want %h", ntx, data_m, words[ntx % 3]);
        end
        ntx++;
      end
    end
    tests++;
    if (ntx !== 3 || ovr_m !== 1'b0) begin
      fails++;
      $display("FAIL b2b_count: got %0d transfers ovr=%b want 3 ovr=0", ntx, ovr_m);
    end
  endtask

  task automatic test_resync();
    logic [5:0] bits = 6'b11_0101;
    logic [5:0] fs   = 6'b10_1000;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1, bits[5-i], fs[5-i]);
      cycle();
      tests++;
      if (obs_m !== exp_m || obs_l !== exp_l || fe_m !== (i == 2)) begin
        fails++;
        $display("FAIL resync_bit%0d: got msb=%b lsb=%b want msb=%b lsb=%b",
                 i, obs_m, obs_l, exp_m, exp_l);
      end
    end
    tests++;
    if (data_m !== 4'b0101 || data_l !== 4'b1010 || valid_m !== 1'b1) begin
      fails++;
      $display("FAIL resync_word: got msb=%b lsb=%b want 0101 1010", data_m, data_l);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bits = 8'b1001_1100;
    out_ready = 1;
    drive(1, 1, 1); cycle();
    drive(1, 0, 0); cycle();
    reset = 1;
    model_reset();
    #1;
    tests++;
    if (obs_m !== '0 || obs_l !== '0) begin
      fails++;
      $display("FAIL reset_async: got msb=%b lsb=%b want all zero", obs_m, obs_l);
    end
    cycle();
    reset = 0;
    drive(1, 1, 0);
    cycle();
    tests++;
    if (busy_m !== 1'b0 || obs_m !== exp_m || obs_l !== exp_l) begin
      fails++;
      $display("FAIL reset_needs_start: got busy=%b want 0", busy_m);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, bits[7-i], (i % 4) == 0);
      cycle();
      tests++;
      if (obs_m !== exp_m || obs_l !== exp_l) begin
        fails++;
        $display("FAIL reset_mid_bit%0d: got msb=%b lsb=%b want msb=%b lsb=%b",
                 i, obs_m, obs_l, exp_m, exp_l);
      end
      if (i == 3) begin
        tests++;
        if (data_m !== 4'b1001 || data_l !== 4'b1001) begin
          fails++;
          $display("FAIL reset_mid_word1: got %b/%b want 1001/1001", data_m, data_l);
        end
      end
    end
    tests++;
    if (data_m !== 4'b1100 || data_l !== 4'b0011) begin
      fails++;
      $display("FAIL reset_mid_word2: got %b/%b want 1100/0011", data_m, data_l);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 6) == 0));
      out_ready   = 1'($urandom_range(0, 2) != 0);
      clr_overrun = 1'($urandom_range(0, 9) == 0);
      cycle();
      tests++;
      if (obs_m !== exp_m || obs_l !== exp_l) begin
        fails++;
        $display("FAIL random_cycle%0d: got msb=%b lsb=%b want msb=%b lsb=%b",
                 cyc, obs_m, obs_l, exp_m, exp_l);
      end
    end
    clr_overrun = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
